arf_stream_responder: RTL

- Synthesizable responder for the pull-style req/ack channel that drives an arf input port such as din_req_0/din_ack_0/din_0.
- Buffers words written by a local push interface in an internal FIFO.
- Answers each upstream request with a one-cycle ack and the head word.
- Replaces the simulation-only producer when arf graphs are placed in real designs; it sits between the host/DMA write side and the arf "in" operator.

---
 rtl/arf_stream_responder_sync_fifo.sv | 58 +++++
 rtl/arf_stream_responder.sv | 59 +++++
 2 files changed

// File: rtl/arf_stream_responder_sync_fifo.sv
// Synchronous FIFO buffering pushed words for the stream responder.
// Occupancy is tracked in a registered level so pointers can wrap without an extra bit.
module arf_stream_responder_sync_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [data_width-1:0]      push_data,
    input  logic                       pop,
    output logic [data_width-1:0]      head,
    output logic [$clog2(depth):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int aw = $clog2(depth);
    localparam int lw = aw + 1;

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == lw'(depth));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + lw'(1);
                2'b01:   level <= level - lw'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/arf_stream_responder.sv
// Pull-style req/ack responder feeding an arf input port from a locally written FIFO.
// Each request is answered with a single-cycle ack carrying the head word on dout.
module arf_stream_responder #(
    parameter int                    data_width    = 32,
    parameter int                    depth         = 8,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [data_width-1:0]      wr_data,
    output logic                       wr_full,
    input  logic                       req,
    output logic                       ack,
    output logic [data_width-1:0]      dout,
    output logic [$clog2(depth):0]     level,
    output logic [31:0]                count,
    output logic                       overflow
);
    logic [data_width-1:0] head;
    logic                  empty;
    logic                  pop_go;

    // Gating on ~ack forces a gap cycle between acks, so each ack is a single pulse.
    assign pop_go = req & ~ack & ~empty;

    arf_stream_responder_sync_fifo #(
        .data_width (data_width),
        .depth      (depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop_go),
        .head      (head),
        .level     (level),
        .full      (wr_full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack      <= 1'b0;
            dout     <= initial_value;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ack <= pop_go;
            if (pop_go) begin
                dout  <= head;
                count <= count + 32'd1;
            end
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
